// File: rtl/spi_shifter.sv
// SPI mode-0 byte engine for the SD card port: one-byte input holding
// register from the TX FIFO, one-byte output holding register to the RX FIFO,
// programmable SCLK half-period and a counted receive-only burst that clocks
// 0xFF fill bytes.
//
// Handshakes: wr_req is honoured only while in_full=0 (data_in is latched and
// in_full rises on that edge; wr_req while in_full=1 is dropped). rd_req is
// honoured only while out_full=1 and clears out_full on that edge. A byte never
// starts while out_full=1, so a capture and a pop never land on the same edge.
module spi_shifter (
  input  logic        C100M,
  input  logic        RESET_n,
  input  logic [7:0]  clk_div,
  input  logic [1:0]  mode,
  input  logic [12:0] new_rx_length,
  input  logic        set_rx_length,
  input  logic        wr_req,
  input  logic [7:0]  data_in,
  input  logic        rd_req,
  output logic [7:0]  data_out,
  output logic        in_full,
  output logic        out_full,
  output logic        busy,
  input  logic        MISO,
  output logic        MOSI,
  output logic        SCLK
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic [7:0]  div_lat;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  in_reg;
  logic        cap;
  logic [12:0] rx_count;

  logic [1:0]  mode_eff;
  logic        half_done;
  logic        start_tx;
  logic        start_rx;
  logic        go_high;
  logic        go_low;
  logic        byte_end;

  // Reserved mode 3 is treated exactly like TX-only.
  assign mode_eff  = (mode == 2'd3) ? 2'd0 : mode;
  assign half_done = (div_cnt == div_lat);

  // SCLK is high only in HIGH; MOSI idles high and otherwise shows the TX MSB,
  // which only moves on falling transitions.
  assign SCLK = (state == HIGH);
  assign MOSI = (state == IDLE) ? 1'b1 : tx_sh[7];
  assign busy = (state != IDLE) | in_full | ((mode == 2'd1) & (rx_count != 13'd0));

  // State register.
  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and per-cycle event decode.
  always_comb begin
    state_nxt = state;
    start_tx  = 1'b0;
    start_rx  = 1'b0;
    go_high   = 1'b0;
    go_low    = 1'b0;
    byte_end  = 1'b0;
    case (state)
      IDLE: begin
        if (!out_full) begin
          if (in_full && (mode_eff != 2'd1)) begin
            start_tx  = 1'b1;
            state_nxt = LOW;
          end else if ((mode_eff == 2'd1) && (rx_count != 13'd0)) begin
            start_rx  = 1'b1;
            state_nxt = LOW;
          end
        end
      end
      LOW: begin
        if (half_done) begin
          go_high   = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (half_done) begin
          if (bit_cnt == 3'd7) begin
            byte_end  = 1'b1;
            state_nxt = IDLE;
          end else begin
            go_low    = 1'b1;
            state_nxt = LOW;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath: divider, bit counter, TX/RX shifters, per-byte latches.
  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) begin
      bit_cnt <= 3'd0;
      div_cnt <= 8'd0;
      div_lat <= 8'd0;
      tx_sh   <= 8'hFF;
      rx_sh   <= 8'h00;
      cap     <= 1'b0;
    end else if (start_tx || start_rx) begin
      tx_sh   <= start_tx ? in_reg : 8'hFF;
      div_lat <= clk_div;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      cap     <= (mode_eff == 2'd1) || (mode_eff == 2'd2);
    end else if (state != IDLE) begin
      div_cnt <= half_done ? 8'd0 : div_cnt + 8'd1;
      if (go_high) rx_sh <= {rx_sh[6:0], MISO};
      if (go_low) begin
        tx_sh   <= {tx_sh[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Input holding register: fill on an accepted write, drain on TX byte start.
  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) begin
      in_reg  <= 8'h00;
      in_full <= 1'b0;
    end else if (start_tx) begin
      in_full <= 1'b0;
    end else if (wr_req && !in_full) begin
      in_reg  <= data_in;
      in_full <= 1'b1;
    end
  end

  // Output holding register: capture at byte end when flagged, pop on rd_req.
  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) begin
      data_out <= 8'h00;
      out_full <= 1'b0;
    end else if (byte_end && cap) begin
      data_out <= rx_sh;
      out_full <= 1'b1;
    end else if (rd_req) begin
      out_full <= 1'b0;
    end
  end

  // RX burst counter: an explicit load beats a same-cycle decrement.
  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n)          rx_count <= 13'd0;
    else if (set_rx_length) rx_count <= new_rx_length;
    else if (start_rx)      rx_count <= rx_count - 13'd1;
  end

endmodule

// File: tb/tb_spi_shifter.sv
// Directed-plus-random bench for spi_shifter. A card model watches SCLK,
// records MOSI at each rising edge into whole bytes and serves MISO bits from
// a byte table; expected bytes come from what the bench wrote or served.
module tb_spi_shifter;

  logic        C100M;
  logic        RESET_n;
  logic [7:0]  clk_div;
  logic [1:0]  mode;
  logic [12:0] new_rx_length;
  logic        set_rx_length;
  logic        wr_req;
  logic [7:0]  data_in;
  logic        rd_req;
  logic [7:0]  data_out;
  logic        in_full;
  logic        out_full;
  logic        busy;
  logic        MISO;
  logic        MOSI;
  logic        SCLK;

  int total;
  int bad;

  // card model state
  int unsigned rises;
  int unsigned miso_base;
  int unsigned miso_idx;
  int          mon_bits;
  logic [7:0]  mon_sh;
  logic [7:0]  tx_seen[$];
  logic        sclk_q;
  logic        miso_drv;
  logic        loopback;
  logic [7:0]  miso_arr[16];

  // scoreboard
  logic [7:0]  exp_q[$];
  int          tx_rd;

  spi_shifter dut (
    .C100M         (C100M),
    .RESET_n       (RESET_n),
    .clk_div       (clk_div),
    .mode          (mode),
    .new_rx_length (new_rx_length),
    .set_rx_length (set_rx_length),
    .wr_req        (wr_req),
    .data_in       (data_in),
    .rd_req        (rd_req),
    .data_out      (data_out),
    .in_full       (in_full),
    .out_full      (out_full),
    .busy          (busy),
    .MISO          (MISO),
    .MOSI          (MOSI),
    .SCLK          (SCLK)
  );

  // clock / reset block
  initial C100M = 1'b0;
  always #5 C100M = ~C100M;

  assign MISO = loopback ? MOSI : miso_drv;

  // Card model: MOSI captured on SCLK rise, MISO bit presented while SCLK low.
  always @(negedge C100M) begin
    if (!RESET_n) begin
      mon_bits = 0;
    end else if (SCLK && !sclk_q) begin
      rises    = rises + 1;
      mon_sh   = {mon_sh[6:0], MOSI};
      mon_bits = mon_bits + 1;
      if (mon_bits == 8) begin
        tx_seen.push_back(mon_sh);
        mon_bits = 0;
      end
    end
    sclk_q   = SCLK;
    miso_idx = rises - miso_base;
    miso_drv = miso_arr[(miso_idx / 8) % 16][7 - (miso_idx % 8)];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_tx(input logic [7:0] b);
    check("mosi_byte_present", (tx_seen.size() > tx_rd), 1);
    if (tx_seen.size() > tx_rd) begin
      check("mosi_byte", tx_seen[tx_rd], b);
      tx_rd++;
    end
  endtask

  task automatic wait_full();
    int k = 0;
    while (!out_full && k < 20000) begin k++; @(negedge C100M); end
    check("out_full_wait", out_full, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20000) begin k++; @(negedge C100M); end
    check("busy_wait", busy, 0);
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1; @(negedge C100M); rd_req = 1'b0;
  endtask

  task automatic load_rx_len(input int n);
    mode = 2'd1; new_rx_length = 13'(n); set_rx_length = 1'b1;
    @(negedge C100M);
    set_rx_length = 1'b0;
  endtask

  // driver: one TX byte, checked for MOSI content and exact duration
  task automatic tx_byte(input logic [7:0] b, input logic [7:0] d, input logic [1:0] m);
    int cyc;
    int unsigned r0;
    clk_div = d; mode = m; r0 = rises;
    data_in = b; wr_req = 1'b1;
    @(negedge C100M);
    wr_req = 1'b0;
    cyc = 0;
    while (busy && cyc < 10000) begin cyc++; @(negedge C100M); end
    check("tx_busy_cycles", cyc, 16 * (int'(d) + 1) + 1);
    check("tx_rises", rises - r0, 8);
    check("tx_out_full", out_full, 0);
    check_tx(b);
  endtask

  // driver: RX-only burst of n bytes served from miso_arr[0..n-1]
  task automatic rx_burst(input int n, input logic [7:0] d);
    int unsigned r0;
    logic [7:0] e;
    clk_div = d; miso_base = rises; r0 = rises;
    @(negedge C100M);
    load_rx_len(n);
    for (int i = 0; i < n; i++) begin
      wait_full();
      e = exp_q.pop_front();
      check("rx_data", data_out, e);
      repeat ($urandom_range(0, 3)) @(negedge C100M);
      pulse_rd();
    end
    wait_idle();
    check("rx_rises", rises - r0, 8 * n);
    for (int i = 0; i < n; i++) check_tx(8'hFF);
    mode = 2'd0;
  endtask

  initial begin
    int k;
    int n;
    int unsigned r0;
    logic [7:0] b;

    total = 0; bad = 0; tx_rd = 0;
    rises = 0; miso_base = 0; mon_bits = 0; mon_sh = 8'h00; sclk_q = 1'b0;
    miso_drv = 1'b1; loopback = 1'b0;
    for (int i = 0; i < 16; i++) miso_arr[i] = 8'h00;
    RESET_n = 1'b0; clk_div = 8'd0; mode = 2'd0; new_rx_length = 13'd0;
    set_rx_length = 1'b0; wr_req = 1'b0; data_in = 8'h00; rd_req = 1'b0;
    repeat (3) @(negedge C100M);

    // reset state
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_in_full", in_full, 0);
    check("rst_out_full", out_full, 0);
    check("rst_busy", busy, 0);
    RESET_n = 1'b1;
    repeat (2) @(negedge C100M);

    // TX 0xA5 at full rate, then random TX bytes (mode 0 and reserved 3)
    tx_byte(8'hA5, 8'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tx_byte(8'($urandom), 8'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0);
    end

    // RX burst 0x3C, 0xFF, 0x00 at clk_div=1
    miso_arr[0] = 8'h3C; miso_arr[1] = 8'hFF; miso_arr[2] = 8'h00;
    exp_q.push_back(8'h3C); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    rx_burst(3, 8'd1);
    check("rx_busy_after", busy, 0);

    // random RX bursts
    for (int j = 0; j < 2; j++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        miso_arr[i] = b;
        exp_q.push_back(b);
      end
      rx_burst(n, 8'($urandom_range(0, 2)));
    end

    // backpressure: full output register stalls the burst
    clk_div = 8'd0; miso_base = rises;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      miso_arr[i] = b;
      exp_q.push_back(b);
    end
    @(negedge C100M);
    load_rx_len(2);
    wait_full();
    r0 = rises;
    repeat (50) @(negedge C100M);
    check("bp_no_rises", rises - r0, 0);
    check("bp_sclk_low", SCLK, 0);
    check("bp_out_full", out_full, 1);
    check("bp_data0", data_out, exp_q.pop_front());
    rd_req = 1'b1;
    @(negedge C100M);
    rd_req = 1'b0;
    k = 1;
    while (!SCLK && k < 100) begin k++; @(negedge C100M); end
    check("bp_restart_latency", k, 3);
    wait_full();
    check("bp_data1", data_out, exp_q.pop_front());
    pulse_rd();
    wait_idle();
    check_tx(8'hFF);
    check_tx(8'hFF);
    mode = 2'd0;

    // duplex loopback 0x55 then 0xC3, third write refused while held
    loopback = 1'b1; mode = 2'd2; clk_div = 8'($urandom_range(0, 2));
    data_in = 8'h55; wr_req = 1'b1;
    @(negedge C100M);
    wr_req = 1'b0;
    k = 0;
    while (in_full && k < 100) begin k++; @(negedge C100M); end
    check("dx_first_started", in_full, 0);
    data_in = 8'hC3; wr_req = 1'b1;
    @(negedge C100M);
    check("dx_second_held", in_full, 1);
    data_in = 8'h99;
    @(negedge C100M);
    wr_req = 1'b0;
    check("dx_still_full", in_full, 1);
    wait_full();
    check("dx_data0", data_out, 8'h55);
    pulse_rd();
    wait_full();
    check("dx_data1", data_out, 8'hC3);
    pulse_rd();
    wait_idle();
    check("dx_no_third", out_full, 0);
    check_tx(8'h55);
    check_tx(8'hC3);
    check("dx_no_extra_tx", tx_seen.size(), tx_rd);
    loopback = 1'b0; mode = 2'd0;

    // clk_div change mid-byte affects only the next byte
    b = 8'($urandom);
    clk_div = 8'd255; data_in = b; wr_req = 1'b1;
    @(negedge C100M);
    wr_req = 1'b0;
    k = 0;
    while (!SCLK && k < 2000) begin k++; @(negedge C100M); end
    n = 0;
    while (SCLK && n < 1000) begin n++; @(negedge C100M); end
    check("div_high_half", n, 256);
    clk_div = 8'd0;
    n = 0;
    while (!SCLK && n < 1000) begin n++; @(negedge C100M); end
    check("div_low_half", n, 256);
    wait_idle();
    check_tx(b);
    tx_byte(8'($urandom), 8'd0, 2'd0);

    // reset during bit 3 of an RX byte
    clk_div = 8'd3; miso_base = rises;
    miso_arr[0] = 8'($urandom); miso_arr[1] = 8'($urandom);
    r0 = rises;
    @(negedge C100M);
    load_rx_len(2);
    k = 0;
    while ((rises - r0) < 4 && k < 2000) begin k++; @(negedge C100M); end
    RESET_n = 1'b0;
    #1;
    check("mid_rst_sclk", SCLK, 0);
    check("mid_rst_mosi", MOSI, 1);
    check("mid_rst_in_full", in_full, 0);
    check("mid_rst_out_full", out_full, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge C100M);
    RESET_n = 1'b1; mode = 2'd0;
    r0 = rises;
    repeat (40) @(negedge C100M);
    check("post_rst_out_full", out_full, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_no_rises", rises - r0, 0);
    check("post_rst_data_out", data_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
